// File: rtl/keypad_pkg.sv
// Shared keypad types and defaults for the column scanner, row debouncers and key decoder.
package keypad_pkg;

    localparam int COLS              = 4;
    localparam int DB_COUNT_DEF      = 67500;
    localparam int SETTLE_CYCLES_DEF = 4;

    typedef logic [$clog2(COLS)-1:0] col_idx_t;
    typedef logic [COLS-1:0]         col_onehot_t;

    // Bit COLS-1 (column 0) wins, so simultaneous presses never give a multi-hot result.
    function automatic col_onehot_t prio_onehot(input col_onehot_t p);
        col_onehot_t r;
        r = '0;
        for (int i = 0; i < COLS; i++) begin
            if (p[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Row-line debouncer bus: raw row line and column drive in, debounced press flag and column out.
interface debounce_if;
    import keypad_pkg::*;

    logic        button_in;
    col_onehot_t columnas;
    logic        DB_out;
    col_onehot_t columna_presionada;

    modport master (output button_in, columnas, input  DB_out, columna_presionada);
    modport slave  (input  button_in, columnas, output DB_out, columna_presionada);
endinterface

// File: rtl/debounce_channel.sv
// One column's debounced state: toggles after DB_COUNT consecutive opposite samples.
// Latency: state changes on the edge of the qualifying sample; no backpressure, samples only when sample_vld.
module debounce_channel #(
    parameter int DB_COUNT = keypad_pkg::DB_COUNT_DEF
) (
    input  logic clk,
    input  logic n_reset,
    input  logic sample_vld,
    input  logic sync_in,
    output logic pressed
);
    localparam int             CNT_W    = $clog2(DB_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the current state restarts the run, so one bounce costs a full recount.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            cnt     <= '0;
            pressed <= 1'b0;
        end else if (sample_vld) begin
            if (sync_in == pressed) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                pressed <= ~pressed;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/debounce.sv
// Keypad row debouncer: synchronizes the row line, aligns the column drive and runs one channel per column.
// Latency: SYNC_STAGES + SETTLE_CYCLES + DB_COUNT samples to a state change, outputs one clk later; no backpressure.
module debounce
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DB_COUNT      = DB_COUNT_DEF
) (
    input  logic     clk,
    input  logic     n_reset,
    debounce_if.slave bus
);
    localparam int                ST_W        = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [ST_W-1:0]   SETTLE_LOAD = ST_W'(SETTLE_CYCLES);
    localparam logic [ST_W-1:0]   ST_ONE      = ST_W'(1);

    logic [SYNC_STAGES-1:0] btn_sync;
    col_onehot_t            col_pipe [SYNC_STAGES];
    logic [ST_W-1:0]        settle_cnt;
    logic                   sync_in;
    col_onehot_t            col_d;
    col_onehot_t            col_next;
    logic                   sample_vld;
    col_onehot_t            pressed;

    assign sync_in  = btn_sync[SYNC_STAGES-1];
    assign col_d    = col_pipe[SYNC_STAGES-1];
    assign col_next = col_pipe[SYNC_STAGES-2];

    // The column drive goes through the same depth as the row line so each sample pairs with its own column.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            btn_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                col_pipe[i] <= '0;
            end
        end else begin
            btn_sync    <= {btn_sync[SYNC_STAGES-2:0], bus.button_in};
            col_pipe[0] <= bus.columnas;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                col_pipe[i] <= col_pipe[i-1];
            end
        end
    end

    // Reload on the same edge col_d takes its new value, so exactly SETTLE_CYCLES samples are dropped.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            settle_cnt <= '0;
        end else if (col_next != col_d) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - ST_ONE;
        end
    end

    assign sample_vld = (settle_cnt == '0) && $onehot(col_d);

    for (genvar k = 0; k < COLS; k++) begin : g_chan
        debounce_channel #(
            .DB_COUNT (DB_COUNT)
        ) u_chan (
            .clk        (clk),
            .n_reset    (n_reset),
            .sample_vld (sample_vld && col_d[k]),
            .sync_in    (sync_in),
            .pressed    (pressed[k])
        );
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            bus.DB_out             <= 1'b0;
            bus.columna_presionada <= '0;
        end else begin
            bus.DB_out             <= |pressed;
            bus.columna_presionada <= prio_onehot(pressed);
        end
    end
endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: phase table with end-of-phase expectations, a bounce-restart sequence and random traffic,
// every cycle also compared against a history-based reference model.
module tb_debounce;
    import keypad_pkg::*;

    localparam int DB    = 4;
    localparam int ST    = 1;
    localparam int SS    = 2;
    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic n_reset;

    debounce_if bus ();

    debounce #(
        .SYNC_STAGES   (SS),
        .SETTLE_CYCLES (ST),
        .DB_COUNT      (DB)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sc    = 0;

    // Reference model: raw input history (newest first), per-column run lengths and debounced states.
    typedef struct packed {
        logic       btn;
        logic [3:0] col;
    } in_t;

    in_t        hist[$];
    int         cnt_m[4];
    bit         prs_m[4];
    logic       exp_db;
    logic [3:0] exp_col;

    function automatic void model_reset();
        hist = {};
        for (int i = 0; i < ST + 2; i++) hist.push_back('0);
        for (int c = 0; c < 4; c++) begin
            cnt_m[c] = 0;
            prs_m[c] = 1'b0;
        end
        exp_db  = 1'b0;
        exp_col = '0;
    endfunction

    // A sample is the input from two clocks ago; it counts if that column value was already held ST clocks before.
    function automatic void model_edge();
        in_t s;
        in_t now_in;
        bit  ok;
        int  k;
        if (n_reset) begin
            model_reset();
            return;
        end
        exp_db  = 1'b0;
        exp_col = '0;
        for (int c = 0; c < 4; c++) if (prs_m[c]) exp_db = 1'b1;
        for (int c = 3; c >= 0; c--) if (prs_m[c] && exp_col == '0) exp_col[c] = 1'b1;
        s  = hist[1];
        ok = $onehot(s.col);
        for (int j = 1; j <= ST; j++) if (hist[1+j].col != s.col) ok = 1'b0;
        if (ok) begin
            k = 0;
            for (int c = 0; c < 4; c++) if (s.col[c]) k = c;
            if (s.btn != prs_m[k]) begin
                cnt_m[k]++;
                if (cnt_m[k] == DB) begin
                    prs_m[k] = ~prs_m[k];
                    cnt_m[k] = 0;
                end
            end else begin
                cnt_m[k] = 0;
            end
        end
        now_in.btn = bus.button_in;
        now_in.col = bus.columnas;
        hist.push_front(now_in);
        void'(hist.pop_back());
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        sc++;
        tests++;
        if (bus.DB_out !== exp_db || bus.columna_presionada !== exp_col) begin
            fails++;
            $display("FAIL model cyc=%0d: DB_out=%b columna_presionada=%b, expected DB_out=%b columna_presionada=%b",
                     cyc, bus.DB_out, bus.columna_presionada, exp_db, exp_col);
        end
    endtask

    task automatic check(input string name, input logic edb, input logic [3:0] ecol);
        tests++;
        if (bus.DB_out !== edb || bus.columna_presionada !== ecol) begin
            fails++;
            $display("FAIL %s: DB_out=%b columna_presionada=%b, required DB_out=%b columna_presionada=%b",
                     name, bus.DB_out, bus.columna_presionada, edb, ecol);
        end
    endtask

    task automatic drive(input bit r, input logic [3:0] c, input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            n_reset       = r;
            bus.columnas  = c;
            bus.button_in = b;
            step();
        end
    endtask

    typedef struct {
        string      name;
        bit         rst;
        bit         scan;
        logic [3:0] press;
        logic [3:0] col;
        bit         btn;
        bit         bnc;
        int         ncyc;
        logic       exp_db;
        logic [3:0] exp_col;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, bit r, bit s, logic [3:0] p, logic [3:0] c, bit b, bit bn,
                                int ncy, logic edb, logic [3:0] ec);
        vec_t v;
        v.name = n;  v.rst = r;   v.scan = s;   v.press = p;  v.col = c;
        v.btn  = b;  v.bnc = bn;  v.ncyc = ncy; v.exp_db = edb; v.exp_col = ec;
        return v;
    endfunction

    initial begin
        logic [3:0] base;
        logic [3:0] one;
        logic [3:0] c;
        logic [3:0] mask;
        bit         b;
        int         hold;

        base = 4'b1000;
        one  = 4'b0001;
        n_reset       = 1'b1;
        bus.columnas  = '0;
        bus.button_in = 1'b0;
        model_reset();

        //               name            rst scan press    col      btn bnc cyc db col
        tbl.push_back(mk("reset_hold",    1, 1, 4'b1111, 4'b0000, 0, 0, 20, 0, 4'b0000));
        tbl.push_back(mk("after_reset",   0, 1, 4'b1111, 4'b0000, 0, 0,  1, 0, 4'b0000));
        tbl.push_back(mk("idle_scan",     0, 1, 4'b0000, 4'b0000, 0, 0, 64, 0, 4'b0000));
        tbl.push_back(mk("press_col0",    0, 1, 4'b1000, 4'b0000, 0, 0, 64, 1, 4'b1000));
        tbl.push_back(mk("release_col0",  0, 1, 4'b0000, 4'b0000, 0, 0, 64, 0, 4'b0000));
        tbl.push_back(mk("bounce_col1",   0, 0, 4'b0000, 4'b0100, 0, 1, 40, 0, 4'b0000));
        tbl.push_back(mk("steady_col1",   0, 0, 4'b0000, 4'b0100, 1, 0, 10, 1, 4'b0100));
        tbl.push_back(mk("rel_col1",      0, 0, 4'b0000, 4'b0100, 0, 0, 10, 0, 4'b0000));
        tbl.push_back(mk("lat_press_pre", 0, 0, 4'b0000, 4'b1000, 1, 0,  7, 0, 4'b0000));
        tbl.push_back(mk("lat_press",     0, 0, 4'b0000, 4'b1000, 1, 0,  1, 1, 4'b1000));
        tbl.push_back(mk("lat_rel_pre",   0, 0, 4'b0000, 4'b1000, 0, 0,  6, 1, 4'b1000));
        tbl.push_back(mk("lat_rel",       0, 0, 4'b0000, 4'b1000, 0, 0,  1, 0, 4'b0000));
        tbl.push_back(mk("two_keys",      0, 1, 4'b0101, 4'b0000, 0, 0, 64, 1, 4'b0100));
        tbl.push_back(mk("col1_released", 0, 1, 4'b0001, 4'b0000, 0, 0, 64, 1, 4'b0001));
        tbl.push_back(mk("hold_col3",     0, 0, 4'b0000, 4'b0001, 1, 0,  5, 1, 4'b0001));
        tbl.push_back(mk("part_release",  0, 0, 4'b0000, 4'b0001, 0, 0,  2, 1, 4'b0001));
        tbl.push_back(mk("scan_zero",     0, 0, 4'b0000, 4'b0000, 1, 0, 20, 1, 4'b0001));
        tbl.push_back(mk("scan_multi",    0, 0, 4'b0000, 4'b1100, 1, 0, 20, 1, 4'b0001));
        tbl.push_back(mk("resume_pre",    0, 0, 4'b0000, 4'b0001, 0, 0,  5, 1, 4'b0001));
        tbl.push_back(mk("resume_done",   0, 0, 4'b0000, 4'b0001, 0, 0,  1, 0, 4'b0000));
        tbl.push_back(mk("midcount",      0, 0, 4'b0000, 4'b0010, 1, 0,  6, 0, 4'b0000));
        tbl.push_back(mk("reset_pulse",   1, 0, 4'b0000, 4'b0010, 1, 0,  1, 0, 4'b0000));
        tbl.push_back(mk("post_rst_3",    0, 0, 4'b0000, 4'b0010, 1, 0,  7, 0, 4'b0000));
        tbl.push_back(mk("post_rst_4",    0, 0, 4'b0000, 4'b0010, 1, 0,  1, 1, 4'b0010));

        foreach (tbl[t]) begin
            for (int i = 0; i < tbl[t].ncyc; i++) begin
                n_reset = tbl[t].rst;
                if (tbl[t].scan) begin
                    bus.columnas  = base >> ((sc / DWELL) % 4);
                    bus.button_in = |(bus.columnas & tbl[t].press);
                end else begin
                    bus.columnas  = tbl[t].col;
                    bus.button_in = tbl[t].bnc ? 1'((i / 2) % 2) : tbl[t].btn;
                end
                step();
            end
            check(tbl[t].name, tbl[t].exp_db, tbl[t].exp_col);
        end

        // Release of column 2 interrupted by one pressed sample must start counting again from zero.
        drive(1'b0, 4'b0010, 1'b0, 3);
        drive(1'b0, 4'b0010, 1'b1, 1);
        drive(1'b0, 4'b0010, 1'b0, 5);
        check("bounce_restart_hold", 1'b1, 4'b0010);
        drive(1'b0, 4'b0010, 1'b0, 2);
        check("bounce_restart_rel", 1'b0, 4'b0000);

        hold = 0;
        mask = 4'b0000;
        c    = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) mask = 4'($urandom());
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    8:       c = 4'b0000;
                    9:       c = 4'($urandom());
                    default: c = one << $urandom_range(0, 3);
                endcase
                hold = $urandom_range(1, 12);
            end
            hold--;
            b = |(c & mask);
            if ($urandom_range(0, 19) == 0) b = ~b;
            drive(($urandom_range(0, 799) == 0), c, b, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
